// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and instruction memory.
// The fetch side holds req and addr until ack; rdata is valid in the ack cycle.
interface if_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, fetches over a req/ack bus and buffers one
// instruction as the producer side of the IF/ID pipeline register.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] BUBBLE_INSN = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    if_fetch_unit_if.master        imem,
    output logic [31:0]            PC_if,
    output logic [31:0]            Instruction_if,
    output logic                   EN,
    output logic                   IF_flush
);

    typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_insn_q, buf_insn_d;

    logic        en;
    logic        issue;
    logic        load;
    logic [31:0] target_pc;

    assign target_pc = redirect_pc & 32'hFFFF_FFFC;

    // Every output is forced quiet while reset is asserted, not just after the reset edge.
    assign en    = rst_n & buf_valid_q & ~stall & ~redirect;
    assign issue = (state_q == StIdle) & (~buf_valid_q | en) & ~redirect;

    assign EN             = en;
    assign IF_flush       = rst_n & redirect;
    assign imem.imem_req  = rst_n & (issue | (state_q != StIdle));
    assign imem.imem_addr = (state_q == StIdle) ? pc_q : req_addr_q;
    assign PC_if          = rst_n ? buf_pc_q : 32'h0;
    assign Instruction_if = (rst_n && buf_valid_q) ? buf_insn_q : BUBBLE_INSN;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_addr_d  = req_addr_q;
        buf_valid_d = buf_valid_q;
        buf_pc_d    = buf_pc_q;
        buf_insn_d  = buf_insn_q;
        load        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (redirect) begin
                    pc_d        = target_pc;
                    buf_valid_d = 1'b0;
                end else if (issue) begin
                    if (imem.imem_ack) begin
                        load       = 1'b1;
                        buf_pc_d   = pc_q;
                        buf_insn_d = imem.imem_rdata;
                        pc_d       = pc_q + 32'd4;
                    end else begin
                        req_addr_d = pc_q;
                        state_d    = StWait;
                    end
                end
            end
            StWait: begin
                if (redirect) begin
                    pc_d        = target_pc;
                    buf_valid_d = 1'b0;
                    state_d     = imem.imem_ack ? StIdle : StDrop;
                end else if (imem.imem_ack) begin
                    load       = 1'b1;
                    buf_pc_d   = req_addr_q;
                    buf_insn_d = imem.imem_rdata;
                    pc_d       = req_addr_q + 32'd4;
                    state_d    = StIdle;
                end
            end
            StDrop: begin
                // Wrong-path response: wait it out, only tracking further redirects.
                if (redirect) begin
                    pc_d = target_pc;
                end
                if (imem.imem_ack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            buf_valid_d = 1'b1;
        end else if (en) begin
            buf_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            pc_q        <= RESET_PC;
            req_addr_q  <= 32'h0;
            buf_valid_q <= 1'b0;
            buf_pc_q    <= 32'h0;
            buf_insn_q  <= BUBBLE_INSN;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_addr_q  <= req_addr_d;
            buf_valid_q <= buf_valid_d;
            buf_pc_q    <= buf_pc_d;
            buf_insn_q  <= buf_insn_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed vector table, hand-written corner sequences, and a
// randomized run scored against the architectural instruction stream.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pc_if;
    logic [31:0] insn_if;
    logic        en;
    logic        if_flush;

    int n_checks = 0;
    int n_errors = 0;

    if_fetch_unit_if bus ();

    if_fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .BUBBLE_INSN (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem           (bus),
        .PC_if          (pc_if),
        .Instruction_if (insn_if),
        .EN             (en),
        .IF_flush       (if_flush)
    );

    always #5 clk = ~clk;

    // Memory: data = addr + 0x100, ack after n_wait_q extra cycles of a held request.
    logic        rand_waits = 1'b0;
    int unsigned fixed_wait = 0;
    int unsigned n_wait_q;
    int unsigned cnt_q;

    assign bus.imem_ack   = bus.imem_req && (cnt_q >= n_wait_q);
    assign bus.imem_rdata = bus.imem_addr + 32'h100;

    always_ff @(posedge clk) begin
        if (!rst_n || !bus.imem_req || bus.imem_ack) begin
            cnt_q    <= 0;
            n_wait_q <= rand_waits ? $urandom_range(3, 0) : fixed_wait;
        end else begin
            cnt_q <= cnt_q + 1;
        end
    end

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr;
        logic        en;
        logic [31:0] pc;
        logic [31:0] insn;
        logic        flush;
    } vec_t;

    vec_t vecs [13];

    function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rpc,
                                input logic req, input logic [31:0] addr, input logic e,
                                input logic [31:0] pc, input logic [31:0] insn,
                                input logic fl);
        vec_t v;
        v.stall = s; v.redirect = r; v.rpc = rpc; v.req = req; v.addr = addr;
        v.en = e; v.pc = pc; v.insn = insn; v.flush = fl;
        return v;
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Redirect is held high during reset to show that IF_flush stays quiet.
    task automatic do_reset();
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_1234;
        @(negedge clk);
        chk1("rst.req", bus.imem_req, 1'b0);
        chk1("rst.en", en, 1'b0);
        chk1("rst.flush", if_flush, 1'b0);
        chk32("rst.pc_if", pc_if, 32'h0);
        chk32("rst.insn", insn_if, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        redirect = 1'b0;
    endtask

    logic [31:0] exp_pc;
    logic        prev_hold;
    logic [31:0] prev_addr;
    int          idle;
    logic        found;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1);
    end

    initial begin
        // Zero-wait memory: stream, stall, redirect+stall, redirect near the top of memory.
        vecs[0]  = mk(1'b0, 1'b0, 32'h0,  1'b1, 32'h0,  1'b0, 32'h0,  32'h0,   1'b0);
        vecs[1]  = mk(1'b0, 1'b0, 32'h0,  1'b1, 32'h4,  1'b1, 32'h0,  32'h100, 1'b0);
        vecs[2]  = mk(1'b0, 1'b0, 32'h0,  1'b1, 32'h8,  1'b1, 32'h4,  32'h104, 1'b0);
        vecs[3]  = mk(1'b1, 1'b0, 32'h0,  1'b0, 32'hC,  1'b0, 32'h8,  32'h108, 1'b0);
        vecs[4]  = mk(1'b1, 1'b0, 32'h0,  1'b0, 32'hC,  1'b0, 32'h8,  32'h108, 1'b0);
        vecs[5]  = mk(1'b0, 1'b0, 32'h0,  1'b1, 32'hC,  1'b1, 32'h8,  32'h108, 1'b0);
        vecs[6]  = mk(1'b1, 1'b1, 32'h42, 1'b0, 32'h10, 1'b0, 32'hC,  32'h10C, 1'b1);
        vecs[7]  = mk(1'b0, 1'b0, 32'h0,  1'b1, 32'h40, 1'b0, 32'hC,  32'h0,   1'b0);
        vecs[8]  = mk(1'b0, 1'b0, 32'h0,  1'b1, 32'h44, 1'b1, 32'h40, 32'h140, 1'b0);
        vecs[9]  = mk(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'h48, 1'b0, 32'h44, 32'h144, 1'b1);
        vecs[10] = mk(1'b0, 1'b0, 32'h0,  1'b1, 32'hFFFF_FFFC, 1'b0, 32'h44, 32'h0, 1'b0);
        vecs[11] = mk(1'b0, 1'b0, 32'h0,  1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'hFC, 1'b0);
        vecs[12] = mk(1'b0, 1'b0, 32'h0,  1'b1, 32'h4,  1'b1, 32'h0,  32'h100, 1'b0);

        fixed_wait = 0;
        do_reset();
        for (int i = 0; i < 13; i++) begin
            stall       = vecs[i].stall;
            redirect    = vecs[i].redirect;
            redirect_pc = vecs[i].rpc;
            @(negedge clk);
            chk1($sformatf("v%0d.req", i), bus.imem_req, vecs[i].req);
            chk32($sformatf("v%0d.addr", i), bus.imem_addr, vecs[i].addr);
            chk1($sformatf("v%0d.en", i), en, vecs[i].en);
            chk32($sformatf("v%0d.pc_if", i), pc_if, vecs[i].pc);
            chk32($sformatf("v%0d.insn", i), insn_if, vecs[i].insn);
            chk1($sformatf("v%0d.flush", i), if_flush, vecs[i].flush);
            cyc();
        end
        stall    = 1'b0;
        redirect = 1'b0;

        // Two wait states: request held 3 cycles per fetch, EN once every 3 cycles.
        fixed_wait = 2;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            chk1($sformatf("w2.c%0d.req", c), bus.imem_req, 1'b1);
            chk32($sformatf("w2.c%0d.addr", c), bus.imem_addr, 32'(4 * (c / 3)));
            chk1($sformatf("w2.c%0d.en", c), en, (c >= 3) && (c % 3 == 0));
            if (en) chk32($sformatf("w2.c%0d.pc_if", c), pc_if, 32'(4 * (c / 3 - 1)));
            cyc();
        end

        // Redirect to 0x40 while the 0x10 request waits; its data must be dropped.
        fixed_wait = 3;
        do_reset();
        redirect    = 1'b1;
        redirect_pc = 32'h10;
        @(negedge clk);
        chk1("rw.c0.req", bus.imem_req, 1'b0);
        cyc();
        redirect = 1'b0;
        @(negedge clk);
        chk32("rw.c1.addr", bus.imem_addr, 32'h10);
        cyc();
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        @(negedge clk);
        chk1("rw.c2.flush", if_flush, 1'b1);
        chk1("rw.c2.req", bus.imem_req, 1'b1);
        chk32("rw.c2.addr", bus.imem_addr, 32'h10);
        chk1("rw.c2.en", en, 1'b0);
        cyc();
        redirect = 1'b0;
        @(negedge clk);
        chk32("rw.c3.addr", bus.imem_addr, 32'h10);
        cyc();
        @(negedge clk);
        chk1("rw.c4.ack", bus.imem_ack, 1'b1);
        chk1("rw.c4.en", en, 1'b0);
        cyc();
        @(negedge clk);
        chk1("rw.c5.req", bus.imem_req, 1'b1);
        chk32("rw.c5.addr", bus.imem_addr, 32'h40);
        chk32("rw.c5.insn", insn_if, 32'h0);
        cyc();
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (en) found = 1'b1;
            else cyc();
        end
        chk1("rw.en_seen", found, 1'b1);
        chk32("rw.pc_if", pc_if, 32'h40);
        chk32("rw.insn", insn_if, 32'h140);
        cyc();

        // Reset while a request waits: request dropped at once, restart at RESET_PC.
        fixed_wait = 3;
        do_reset();
        redirect    = 1'b1;
        redirect_pc = 32'h80;
        cyc();
        redirect = 1'b0;
        @(negedge clk);
        chk32("rwait.addr", bus.imem_addr, 32'h80);
        cyc();
        rst_n = 1'b0;
        @(negedge clk);
        chk1("rwait.req_in_reset", bus.imem_req, 1'b0);
        chk1("rwait.en_in_reset", en, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk1("rwait.req_after", bus.imem_req, 1'b1);
        chk32("rwait.addr_after", bus.imem_addr, 32'h0);
        cyc();

        // Random run against the architectural fetch stream.
        rand_waits = 1'b1;
        do_reset();
        exp_pc    = 32'h0;
        prev_hold = 1'b0;
        prev_addr = 32'h0;
        idle      = 0;
        for (int t = 0; t < 4000; t++) begin
            stall       = ($urandom_range(99, 0) < 25);
            redirect    = ($urandom_range(99, 0) < 4);
            redirect_pc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)))
                                                      : $urandom;
            @(negedge clk);
            chk1("rnd.flush", if_flush, redirect);
            if (stall || redirect) chk1("rnd.en_blocked", en, 1'b0);
            if (prev_hold) begin
                chk1("rnd.req_held", bus.imem_req, 1'b1);
                chk32("rnd.addr_stable", bus.imem_addr, prev_addr);
            end
            if (en) begin
                chk32("rnd.pc_if", pc_if, exp_pc);
                chk32("rnd.insn", insn_if, exp_pc + 32'h100);
            end
            if (redirect) begin
                exp_pc = redirect_pc & 32'hFFFF_FFFC;
                idle   = 0;
            end else if (en) begin
                exp_pc = exp_pc + 32'd4;
                idle   = 0;
            end else if (!stall) begin
                idle++;
            end
            chk1("rnd.progress", idle > 16, 1'b0);
            if (idle > 16) idle = 0;
            prev_hold = bus.imem_req && !bus.imem_ack;
            prev_addr = bus.imem_addr;
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
